// File: rtl/sd_cmd_receiver_pkg.sv
// Shared definitions for the SD CMD-line receive path: FSM encoding,
// frame geometry and the CRC7 generator polynomial.
package sd_cmd_receiver_pkg;

  localparam int         FRAME_BITS = 48;
  localparam logic [6:0] CRC_POLY   = 7'h09;

  // Response frame field positions, MSB (start bit) first on the wire.
  localparam int POS_START  = 47;
  localparam int POS_TRANS  = 46;
  localparam int POS_IDX_HI = 45;
  localparam int POS_IDX_LO = 40;
  localparam int POS_ARG_HI = 39;
  localparam int POS_ARG_LO = 8;
  localparam int POS_CRC_HI = 7;
  localparam int POS_CRC_LO = 1;
  localparam int POS_END    = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_RECEIVE    = 2'd2,
    ST_CHECK      = 2'd3
  } state_t;

endpackage

// File: rtl/sd_cmd_receiver_crc7.sv
// Serial CRC7 register, one bit per enabled clock, MSB first.
// Shared with the command transmitter.
module sd_crc7
  import sd_cmd_receiver_pkg::*;
#(
  parameter logic [6:0] POLY = CRC_POLY
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb  = i_bit ^ r_crc[6];
  assign o_crc = r_crc;

  // Galois-style LFSR update; clear has priority over a shift.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_crc <= 7'd0;
    end else if (i_enable) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? POLY : 7'd0);
    end
  end

endmodule

// File: rtl/sd_cmd_receiver.sv
// Host-side SD CMD response deserializer: waits for a start bit, shifts in
// a 48-bit short response, checks framing and CRC7 and reports the result.
module sd_cmd_receiver #(
  parameter int         FRAME_BITS     = sd_cmd_receiver_pkg::FRAME_BITS,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [6:0] CRC_POLY       = sd_cmd_receiver_pkg::CRC_POLY
) (
  input  logic        iSD_clock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iCmd_line,
  output logic        oPad_output_input,
  output logic        oBusy,
  output logic [5:0]  oIndex,
  output logic [31:0] oArgument,
  output logic        oValid,
  output logic        oCrc_error,
  output logic        oFrame_error,
  output logic        oTimeout
);
  import sd_cmd_receiver_pkg::*;

  localparam int         TW        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);
  localparam logic [5:0] FULL_CNT  = 6'(FRAME_BITS);
  // Only the leading 40 bits (start..argument) are covered by the CRC.
  localparam logic [5:0] CRC_LIMIT = 6'(FRAME_BITS - 8);

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]            r_bitcnt;
  logic [TW-1:0]         r_tmo;

  logic       w_crc_clear;
  logic       w_crc_en;
  logic [6:0] w_crc;
  logic       w_frame_err;
  logic       w_crc_err;

  // The receiver never drives the pad; it only ever requests input mode.
  assign oPad_output_input = 1'b0;
  assign oBusy             = (r_state != ST_IDLE);

  assign w_crc_clear = (r_state == ST_IDLE) && iEnable;
  assign w_crc_en    = iEnable &&
                       (((r_state == ST_WAIT_START) && !iCmd_line) ||
                        ((r_state == ST_RECEIVE) && (r_bitcnt < CRC_LIMIT)));

  assign w_frame_err = r_shift[POS_START] | r_shift[POS_TRANS] | ~r_shift[POS_END];
  assign w_crc_err   = (w_crc != r_shift[POS_CRC_HI:POS_CRC_LO]);

  sd_crc7 #(
    .POLY(CRC_POLY)
  ) u_crc (
    .i_clk    (iSD_clock),
    .i_rst    (iReset),
    .i_clear  (w_crc_clear),
    .i_enable (w_crc_en),
    .i_bit    (iCmd_line),
    .o_crc    (w_crc)
  );

  // Receive FSM with registered result pulses and held index/argument.
  always_ff @(posedge iSD_clock) begin
    if (iReset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bitcnt     <= 6'd0;
      r_tmo        <= '0;
      oIndex       <= 6'd0;
      oArgument    <= 32'd0;
      oValid       <= 1'b0;
      oCrc_error   <= 1'b0;
      oFrame_error <= 1'b0;
      oTimeout     <= 1'b0;
    end else begin
      oValid       <= 1'b0;
      oCrc_error   <= 1'b0;
      oFrame_error <= 1'b0;
      oTimeout     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iEnable) begin
            r_state  <= ST_WAIT_START;
            r_tmo    <= '0;
            r_bitcnt <= 6'd0;
          end
        end
        ST_WAIT_START: begin
          r_tmo <= r_tmo + 1'b1;
          if (!iEnable) begin
            r_state <= ST_IDLE;
          end else if (!iCmd_line) begin
            // A start bit on the timeout edge still counts as a start.
            r_shift  <= {r_shift[FRAME_BITS-2:0], iCmd_line};
            r_bitcnt <= 6'd1;
            r_state  <= ST_RECEIVE;
          end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            oTimeout <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        ST_RECEIVE: begin
          if (!iEnable) begin
            r_state <= ST_IDLE;
          end else begin
            r_shift  <= {r_shift[FRAME_BITS-2:0], iCmd_line};
            r_bitcnt <= (r_bitcnt == FULL_CNT) ? r_bitcnt : r_bitcnt + 6'd1;
            if (r_bitcnt == LAST_BIT) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          r_state <= ST_IDLE;
          if (iEnable) begin
            oIndex    <= r_shift[POS_IDX_HI:POS_IDX_LO];
            oArgument <= r_shift[POS_ARG_HI:POS_ARG_LO];
            if (w_frame_err) begin
              oFrame_error <= 1'b1;
            end else if (w_crc_err) begin
              oCrc_error <= 1'b1;
            end else begin
              oValid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
